tag_lookup_ctrl: RTL and testbench
==================================

# tag_lookup_ctrl

Requester-side controller for a synchronous-read tag RAM (one valid bit plus tag per entry). It takes tag lookup requests over a valid/ready handshake, drives the RAM address/data/write-enable port, and consumes the registered-address read data one cycle later. It compares the stored entry against the request tag and returns hit/miss plus eviction information. On an allocating miss it writes the new tag back. It sits between the cache access pipeline and the tag RAM instances.

## Interface
- AWIDTH, 3, index width; DEPTH = 1 << AWIDTH entries
- DWIDTH, 9, RAM word width; bit DWIDTH-1 = valid, bits DWIDTH-2:0 = tag
- clock  in  1  single clock, all state on rising edge
- reset_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  lookup request present
- req_ready  out  1  controller accepts request (IDLE only)
- req_index  in  AWIDTH  entry index
- req_tag  in  DWIDTH-1  tag to compare/allocate
- req_alloc  in  1  on miss, write {1, req_tag} to entry
- rsp_valid  out  1  response present, held until rsp_ready
- rsp_ready  in  1  consumer accepts response
- rsp_hit  out  1  stored valid=1 and stored tag == req_tag
- rsp_evict_valid  out  1  allocating miss replaced a valid entry
- rsp_evict_tag  out  DWIDTH-1  tag that was replaced
- ram_addr  out  AWIDTH  RAM address
- ram_din  out  DWIDTH  RAM write data
- ram_we  out  1  RAM write enable
- ram_dout  in  DWIDTH  RAM read data, valid the cycle after ram_addr is sampled

## Operation
- States: INIT, IDLE, LOOKUP, WRITE, RESP.
- INIT: counter sweeps 0..DEPTH-1. ram_we=1, ram_addr=counter, ram_din=0. After entry DEPTH-1, go to IDLE. Exists only with the Configuration macro.
- IDLE: req_ready=1. ram_addr = req_index, combinational, so the RAM samples it on the accept edge. On req_valid&&req_ready, latch index/tag/alloc and go to LOOKUP.
- LOOKUP: ram_dout holds the stored entry.
  - Compute hit = dout[DWIDTH-1] && dout[DWIDTH-2:0]==tag. Register hit, evict_valid = !hit && alloc && dout[DWIDTH-1], evict_tag = dout[DWIDTH-2:0].
  - Go to WRITE if !hit && alloc, else RESP.
- WRITE: ram_we=1, ram_addr=latched index, ram_din={1'b1, latched tag}; exactly one cycle; then RESP.
- RESP: rsp_valid=1, fields stable. On rsp_ready, go to IDLE.
- Hit with alloc: no write. Miss without alloc: no write, evict_valid=0.
- ram_we=1 only in INIT and WRITE; never two writes per request.

## Timing
- Reset values: req_ready=0, rsp_valid=0, rsp_hit=0, rsp_evict_valid=0, rsp_evict_tag=0, ram_we=0, ram_din=0, ram_addr=0.
- Reset state: INIT with the macro, IDLE without it.
- Accept edge E0 → LOOKUP. Hit or non-allocating miss: rsp_valid after E1. Allocating miss: write at E2, rsp_valid after E2.
- Throughput: one request per 3 cycles (hit, rsp_ready=1), 4 cycles (allocating miss). req_ready=0 outside IDLE; no pipelining.
- rsp_valid does not drop and rsp_* fields do not change until the rsp_ready handshake.
- Reset asserted mid-operation (any state, including WRITE): ram_we and rsp_valid drop immediately (asynchronous), the pending write is abandoned, the FSM restarts per reset state.
- Back-to-back same index: the write completes before the next accept, so the next lookup sees the new entry.

## Configuration
- TAG_CLEAR_ON_RESET_EN defined: INIT state present; after reset the controller clears all DEPTH entries (DEPTH cycles, req_ready=0) before IDLE.
- Not defined: no INIT state or counter; reset goes to IDLE; RAM contents are its preload image.

## Structure
- Package tag_ctrl_pkg: state enum, VALID_BIT = DWIDTH-1, TAG_W = DWIDTH-1, DEPTH computation.
- One natural sub-module: tag_entry_cmp (combinational valid+tag compare producing hit/evict_valid/evict_tag). Everything else lives in the top module.

## Test plan
AWIDTH=3, DWIDTH=9, bench RAM = synchronous-read model with registered address.
- Reset with TAG_CLEAR_ON_RESET_EN: release reset_n → ram_we=1 for 8 cycles, addr 0..7, din 0x000; then req_ready=1.
- Lookup index 3, tag 0x5A, alloc=1 on cleared RAM → hit=0, evict_valid=0, ram_we=1 with addr 3, din 0x15A, rsp_valid 2 edges after accept.
- Repeat index 3, tag 0x5A → hit=1, no ram_we, rsp_valid 1 edge after accept.
- Index 3, tag 0x11, alloc=1 → hit=0, evict_valid=1, evict_tag=0x5A, write din 0x111. Then index 3, tag 0x11, alloc=0 → hit=1.
- Index 5, tag 0x22, alloc=0, miss → no write, evict_valid=0. Hold rsp_ready=0 for 5 cycles → rsp fields stable, req_ready=0 throughout.
- Assert reset_n=0 during WRITE → ram_we=0 in the same cycle, entry unchanged in the RAM model, FSM restarts from INIT.

Source files
------------

// File: rtl/tag_lookup_ctrl_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Package    : tag_ctrl_pkg
// Description: Shared state encoding and geometry helpers for tag_lookup_ctrl.
// Revision   : 1.0 - initial release
// ============================================================================
package tag_ctrl_pkg;

    localparam int DEF_AWIDTH = 3;
    localparam int DEF_DWIDTH = 9;

    typedef enum logic [2:0] {
        ST_INIT   = 3'd0,
        ST_IDLE   = 3'd1,
        ST_LOOKUP = 3'd2,
        ST_WRITE  = 3'd3,
        ST_RESP   = 3'd4
    } state_t;

    function automatic int DEPTH(input int awidth);
        return 1 << awidth;
    endfunction

    function automatic int VALID_BIT(input int dwidth);
        return dwidth - 1;
    endfunction

    function automatic int TAG_W(input int dwidth);
        return dwidth - 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tag_lookup_ctrl_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Interface  : tag_lookup_ctrl_if
// Description: Lookup request / response handshake between cache pipeline
//              (master) and tag lookup controller (slave).
// Revision   : 1.0 - initial release
// ============================================================================
interface tag_lookup_ctrl_if #(
    parameter int AWIDTH = 3,
    parameter int DWIDTH = 9
) ();
    logic              req_valid;
    logic              req_ready;
    logic [AWIDTH-1:0] req_index;
    logic [DWIDTH-2:0] req_tag;
    logic              req_alloc;
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_hit;
    logic              rsp_evict_valid;
    logic [DWIDTH-2:0] rsp_evict_tag;

    modport master (
        output req_valid, req_index, req_tag, req_alloc, rsp_ready,
        input  req_ready, rsp_valid, rsp_hit, rsp_evict_valid, rsp_evict_tag
    );

    modport slave (
        input  req_valid, req_index, req_tag, req_alloc, rsp_ready,
        output req_ready, rsp_valid, rsp_hit, rsp_evict_valid, rsp_evict_tag
    );
endinterface
`default_nettype wire

// File: rtl/tag_lookup_ctrl_entry_cmp.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module     : tag_entry_cmp
// Description: Combinational compare of a stored {valid, tag} entry against a
//              request tag, producing hit and eviction information.
// Revision   : 1.0 - initial release
// ============================================================================
module tag_entry_cmp
    import tag_ctrl_pkg::*;
#(
    parameter int DWIDTH = DEF_DWIDTH
) (
    input  wire logic [DWIDTH-1:0] entry,
    input  wire logic [DWIDTH-2:0] tag,
    input  wire logic              alloc,
    output logic                   hit,
    output logic                   evict_valid,
    output logic [DWIDTH-2:0]      evict_tag
);
    localparam int c_VALID_BIT = VALID_BIT(DWIDTH);

    logic w_valid;

    assign w_valid     = entry[c_VALID_BIT];
    assign hit         = w_valid && (entry[c_VALID_BIT-1:0] == tag);
    assign evict_valid = !hit && alloc && w_valid;
    assign evict_tag   = entry[c_VALID_BIT-1:0];
endmodule
`default_nettype wire

// File: rtl/tag_lookup_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module     : tag_lookup_ctrl
// Description: Requester-side controller for a synchronous-read tag RAM:
//              lookup, hit/miss, allocate-on-miss write-back.
//              Optional macro TAG_CLEAR_ON_RESET_EN adds a RAM clear sweep
//              after reset.
// Revision   : 1.0 - initial release
// ============================================================================
module tag_lookup_ctrl
    import tag_ctrl_pkg::*;
#(
    parameter int AWIDTH = DEF_AWIDTH,
    parameter int DWIDTH = DEF_DWIDTH
) (
    input  wire logic              clock,
    input  wire logic              reset_n,
    tag_lookup_ctrl_if.slave       bus,
    output logic [AWIDTH-1:0]      ram_addr,
    output logic [DWIDTH-1:0]      ram_din,
    output logic                   ram_we,
    input  wire logic [DWIDTH-1:0] ram_dout
);
    localparam int c_TAG_W = TAG_W(DWIDTH);

`ifdef TAG_CLEAR_ON_RESET_EN
    localparam state_t            c_RESET_STATE = ST_INIT;
    localparam logic [AWIDTH:0]   c_CNT_END     = (AWIDTH+1)'(DEPTH(AWIDTH));
    logic [AWIDTH:0]              r_cnt;
`else
    localparam state_t            c_RESET_STATE = ST_IDLE;
`endif

    state_t             r_state;
    logic [AWIDTH-1:0]  r_ram_addr;
    logic [DWIDTH-1:0]  r_ram_din;
    logic               r_ram_we;
    logic [c_TAG_W-1:0] r_tag;
    logic               r_alloc;
    logic               r_req_ready;
    logic               r_rsp_valid;
    logic               r_hit;
    logic               r_evict_valid;
    logic [c_TAG_W-1:0] r_evict_tag;

    logic               w_hit;
    logic               w_evict_valid;
    logic [c_TAG_W-1:0] w_evict_tag;

    tag_entry_cmp #(.DWIDTH(DWIDTH)) u_cmp (
        .entry       (ram_dout),
        .tag         (r_tag),
        .alloc       (r_alloc),
        .hit         (w_hit),
        .evict_valid (w_evict_valid),
        .evict_tag   (w_evict_tag)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= c_RESET_STATE;
            r_ram_addr    <= '0;
            r_ram_din     <= '0;
            r_ram_we      <= 1'b0;
            r_tag         <= '0;
            r_alloc       <= 1'b0;
            r_req_ready   <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_hit         <= 1'b0;
            r_evict_valid <= 1'b0;
            r_evict_tag   <= '0;
`ifdef TAG_CLEAR_ON_RESET_EN
            r_cnt         <= '0;
`endif
        end else begin
            case (r_state)
`ifdef TAG_CLEAR_ON_RESET_EN
                ST_INIT: begin
                    if (r_cnt == c_CNT_END) begin
                        r_ram_we    <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_ram_we    <= 1'b1;
                        r_ram_addr  <= r_cnt[AWIDTH-1:0];
                        r_ram_din   <= '0;
                        r_cnt       <= r_cnt + 1'b1;
                    end
                end
`endif
                ST_IDLE: begin
                    // Ready comes up one cycle after a reset straight into IDLE.
                    if (!r_req_ready) begin
                        r_req_ready <= 1'b1;
                    end else if (bus.req_valid) begin
                        r_ram_addr  <= bus.req_index;
                        r_tag       <= bus.req_tag;
                        r_alloc     <= bus.req_alloc;
                        r_req_ready <= 1'b0;
                        r_state     <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    r_hit         <= w_hit;
                    r_evict_valid <= w_evict_valid;
                    r_evict_tag   <= w_evict_tag;
                    if (!w_hit && r_alloc) begin
                        r_ram_we  <= 1'b1;
                        r_ram_din <= {1'b1, r_tag};
                        r_state   <= ST_WRITE;
                    end else begin
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RESP;
                    end
                end
                ST_WRITE: begin
                    r_ram_we    <= 1'b0;
                    r_rsp_valid <= 1'b1;
                    r_state     <= ST_RESP;
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_ram_we <= 1'b0;
                    r_state  <= c_RESET_STATE;
                end
            endcase
        end
    end

    // While ready, the RAM must see the request index on the accept edge.
    assign ram_addr            = r_req_ready ? bus.req_index : r_ram_addr;
    assign ram_din             = r_ram_din;
    assign ram_we              = r_ram_we;
    assign bus.req_ready       = r_req_ready;
    assign bus.rsp_valid       = r_rsp_valid;
    assign bus.rsp_hit         = r_hit;
    assign bus.rsp_evict_valid = r_evict_valid;
    assign bus.rsp_evict_tag   = r_evict_tag;
endmodule
`default_nettype wire

// File: tb/tb_tag_lookup_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module     : tb_tag_lookup_ctrl
// Description: Self-checking bench for tag_lookup_ctrl with a synchronous-read
//              RAM model and a per-entry reference model.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_tag_lookup_ctrl;
    localparam int AW  = 3;
    localparam int DW  = 9;
    localparam int TW  = DW - 1;
    localparam int DEP = 1 << AW;
`ifdef TAG_CLEAR_ON_RESET_EN
    localparam int INIT_N = DEP;
`else
    localparam int INIT_N = 0;
`endif

    logic          clock   = 1'b0;
    logic          reset_n = 1'b0;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout = '0;
    logic          ram_we;
    logic [DW-1:0] mem     [DEP];
    logic [DW-1:0] exp_mem [DEP];
    int            total = 0;
    int            bad   = 0;

    always #5 clock = ~clock;

    tag_lookup_ctrl_if #(.AWIDTH(AW), .DWIDTH(DW)) bus ();

    tag_lookup_ctrl #(.AWIDTH(AW), .DWIDTH(DW)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .bus      (bus),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_we   (ram_we),
        .ram_dout (ram_dout)
    );

    always @(posedge clock) begin
        if (ram_we === 1'b1) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // After reset release: clear sweep (if built in) then ready.
    task automatic check_init();
        int seen = 0;
        int cyc  = 0;
        while (bus.req_ready !== 1'b1 && cyc < 40) begin
            step();
            cyc++;
            if (ram_we === 1'b1) begin
                total++;
                if (ram_addr !== AW'(seen) || ram_din !== '0) begin
                    bad++;
                    $display("FAIL init_write: addr=%0d din=%h expected addr=%0d din=0", ram_addr, ram_din, seen);
                end
                seen++;
            end
        end
        total++;
        if (cyc !== INIT_N + 1 || seen !== INIT_N) begin
            bad++;
            $display("FAIL init_timing: ready_after=%0d writes=%0d expected %0d and %0d", cyc, seen, INIT_N + 1, INIT_N);
        end
        for (int i = 0; i < DEP; i++) begin
            total++;
            if (mem[i] !== exp_mem[i]) begin
                bad++;
                $display("FAIL init_mem[%0d]: got %h expected %h", i, mem[i], exp_mem[i]);
            end
        end
    endtask

    task automatic test_reset();
        bus.req_valid = 1'b0;
        bus.req_index = '0;
        bus.req_tag   = '0;
        bus.req_alloc = 1'b0;
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < DEP; i++) begin
`ifdef TAG_CLEAR_ON_RESET_EN
            mem[i]     = DW'($urandom);
            exp_mem[i] = '0;
`else
            mem[i]     = '0;
            exp_mem[i] = '0;
`endif
        end
        reset_n = 1'b0;
        step();
        step();
        total++;
        if ({bus.req_ready, bus.rsp_valid, bus.rsp_hit, bus.rsp_evict_valid, bus.rsp_evict_tag,
             ram_we, ram_din, ram_addr} !== '0) begin
            bad++;
            $display("FAIL reset_values: rdy=%b vld=%b hit=%b ev=%b evtag=%h we=%b din=%h addr=%h expected all 0",
                     bus.req_ready, bus.rsp_valid, bus.rsp_hit, bus.rsp_evict_valid, bus.rsp_evict_tag,
                     ram_we, ram_din, ram_addr);
        end
        reset_n = 1'b1;
        check_init();
    endtask

    task automatic do_req(input int idx, input int tag, input bit alloc, input int hold);
        logic [DW-1:0] stored;
        logic          ehit, eev, wr;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        int            lat, nw, cyc;
        wa = '0;
        wd = '0;
        cyc = 0;
        while (bus.req_ready !== 1'b1 && cyc < 20) begin
            step();
            cyc++;
        end
        total++;
        if (bus.req_ready !== 1'b1) begin
            bad++;
            $display("FAIL req_ready_timeout: ready=%b expected 1", bus.req_ready);
            return;
        end
        bus.req_valid = 1'b1;
        bus.req_index = AW'(idx);
        bus.req_tag   = TW'(tag);
        bus.req_alloc = alloc;
        step();
        bus.req_valid = 1'b0;
        bus.req_index = AW'($urandom);
        bus.req_tag   = TW'($urandom);
        bus.req_alloc = 1'($urandom);

        stored = exp_mem[idx];
        ehit   = stored[DW-1] && (stored[TW-1:0] == tag[TW-1:0]);
        wr     = !ehit && alloc;
        eev    = wr && stored[DW-1];

        lat = 0;
        nw  = (ram_we === 1'b1) ? 1 : 0;
        while (bus.rsp_valid !== 1'b1 && lat < 10) begin
            step();
            lat++;
            if (ram_we === 1'b1) begin
                nw++;
                wa = ram_addr;
                wd = ram_din;
            end
        end
        total++;
        if (lat !== (wr ? 2 : 1) || nw !== (wr ? 1 : 0)) begin
            bad++;
            $display("FAIL rsp_latency idx=%0d tag=%h: latency=%0d writes=%0d expected %0d and %0d",
                     idx, tag, lat, nw, wr ? 2 : 1, wr ? 1 : 0);
        end
        if (wr) begin
            total++;
            if (wa !== AW'(idx) || wd !== {1'b1, tag[TW-1:0]}) begin
                bad++;
                $display("FAIL write_port: addr=%0d din=%h expected addr=%0d din=%h",
                         wa, wd, idx, {1'b1, tag[TW-1:0]});
            end
        end
        total++;
        if ({bus.rsp_hit, bus.rsp_evict_valid, bus.rsp_evict_tag} !== {ehit, eev, stored[TW-1:0]}) begin
            bad++;
            $display("FAIL rsp_fields idx=%0d tag=%h: hit=%b ev=%b evtag=%h expected hit=%b ev=%b evtag=%h",
                     idx, tag, bus.rsp_hit, bus.rsp_evict_valid, bus.rsp_evict_tag, ehit, eev, stored[TW-1:0]);
        end
        for (int k = 0; k < hold; k++) begin
            step();
            total++;
            if ({bus.rsp_valid, bus.req_ready, ram_we, bus.rsp_hit, bus.rsp_evict_valid, bus.rsp_evict_tag}
                !== {1'b1, 1'b0, 1'b0, ehit, eev, stored[TW-1:0]}) begin
                bad++;
                $display("FAIL rsp_hold cycle %0d: vld=%b rdy=%b we=%b hit=%b ev=%b evtag=%h expected 1 0 0 %b %b %h",
                         k, bus.rsp_valid, bus.req_ready, ram_we, bus.rsp_hit, bus.rsp_evict_valid,
                         bus.rsp_evict_tag, ehit, eev, stored[TW-1:0]);
            end
        end
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
        total++;
        if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            bad++;
            $display("FAIL rsp_handshake: vld=%b rdy=%b expected 0 1", bus.rsp_valid, bus.req_ready);
        end
        if (wr) exp_mem[idx] = {1'b1, tag[TW-1:0]};
        total++;
        if (mem[idx] !== exp_mem[idx]) begin
            bad++;
            $display("FAIL ram_entry[%0d]: got %h expected %h", idx, mem[idx], exp_mem[idx]);
        end
    endtask

    task automatic test_alloc_and_hit();
        do_req(3, 'h5A, 1'b1, 0);
        do_req(3, 'h5A, 1'b1, 0);
    endtask

    task automatic test_evict();
        do_req(3, 'h11, 1'b1, 0);
        do_req(3, 'h11, 1'b0, 0);
    endtask

    task automatic test_miss_hold();
        do_req(5, 'h22, 1'b0, 5);
    endtask

    task automatic test_back_to_back();
        do_req(2, 'h77, 1'b1, 0);
        do_req(2, 'h77, 1'b0, 0);
        do_req(2, 'h78, 1'b1, 1);
        do_req(2, 'h78, 1'b0, 0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++)
            do_req(int'($urandom_range(0, DEP - 1)), int'($urandom_range(0, 3)) + 'h30,
                   1'($urandom), int'($urandom_range(0, 2)));
    endtask

    task automatic test_reset_in_write();
        int            idx = 6;
        logic [TW-1:0] t;
        int            cyc = 0;
        t = exp_mem[idx][TW-1:0] ^ TW'('h5);
        while (bus.req_ready !== 1'b1 && cyc < 20) begin
            step();
            cyc++;
        end
        bus.req_valid = 1'b1;
        bus.req_index = AW'(idx);
        bus.req_tag   = t;
        bus.req_alloc = 1'b1;
        step();
        bus.req_valid = 1'b0;
        step();
        total++;
        if (ram_we !== 1'b1) begin
            bad++;
            $display("FAIL write_state_entry: we=%b expected 1", ram_we);
        end
        reset_n = 1'b0;
        #1;
        total++;
        if (ram_we !== 1'b0 || bus.rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL async_reset_drop: we=%b vld=%b expected 0 0", ram_we, bus.rsp_valid);
        end
        step();
        step();
        total++;
        if (mem[idx] !== exp_mem[idx]) begin
            bad++;
            $display("FAIL abandoned_write: entry=%h expected %h", mem[idx], exp_mem[idx]);
        end
`ifdef TAG_CLEAR_ON_RESET_EN
        for (int i = 0; i < DEP; i++) exp_mem[i] = '0;
`endif
        reset_n = 1'b1;
        check_init();
        do_req(idx, int'(t), 1'b1, 0);
    endtask

    initial begin
        test_reset();
        test_alloc_and_hit();
        test_evict();
        test_miss_hold();
        test_back_to_back();
        test_random();
        test_reset_in_write();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
